// File: rtl/channel_accumulator_p_pkg.sv
// Shared widths and arithmetic helpers for the channel accumulator datapath.
// Pure package: no state, no latency, no flow control.
package channel_accumulator_p_pkg;

  localparam int DEF_LANES = 16;
  localparam int DEF_IN_W  = 11;
  localparam int DEF_ACC_W = 16;
  localparam int DEF_CNT_W = 5;

  // Widest accumulator the clip helper supports (ACC_W must stay below this).
  localparam int CLIP_W = 64;

  // Takes an (acc_w+1)-bit sum sign-extended to CLIP_W+1 bits and returns
  // {result, ovf}; only the low acc_w bits of result are meaningful.
  function automatic logic [CLIP_W:0] sat_clip(input logic [CLIP_W:0] sum,
                                               input logic [6:0]      acc_w,
                                               input logic            sat);
    logic [CLIP_W-1:0] one;
    logic [CLIP_W-1:0] max_v;
    logic [CLIP_W-1:0] val;
    logic              ovf;
    one   = CLIP_W'(1);
    max_v = (one << (acc_w - 7'd1)) - one;
    ovf   = sum[acc_w] ^ sum[acc_w - 7'd1];
    if (ovf && sat) begin
      val = sum[acc_w] ? ~max_v : max_v;
    end else begin
      val = sum[CLIP_W-1:0];
    end
    return {val, ovf};
  endfunction

  function automatic int lane_lsb(input int lane, input int w);
    return lane * w;
  endfunction

endpackage

// File: rtl/channel_accumulator_p_lane.sv
// One lane: sign-extend, add to running sum (or restart), clip/wrap, flag overflow.
// Purely combinational; no handshake of its own.
module chacc_lane
  import channel_accumulator_p_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int ACC_W = DEF_ACC_W,
  parameter int SAT   = 1
) (
  input  logic [IN_W-1:0]  in_lane,
  input  logic [ACC_W-1:0] acc,
  input  logic             first,
  output logic [ACC_W-1:0] sum,
  output logic             ovf
);

  logic [ACC_W:0] in_ext;
  logic [ACC_W:0] acc_ext;
  logic [ACC_W:0] raw;

  assign in_ext  = {{(ACC_W + 1 - IN_W){in_lane[IN_W-1]}}, in_lane};
  assign acc_ext = first ? '0 : {acc[ACC_W-1], acc};
  assign raw     = acc_ext + in_ext;

  // Truncating to ACC_W+1 keeps the clipped lane value and the overflow bit.
  assign {sum, ovf} = (ACC_W + 1)'(sat_clip({{(CLIP_W - ACC_W){raw[ACC_W]}}, raw},
                                            7'(ACC_W), SAT != 0));

endmodule

// File: rtl/channel_accumulator_p.sv
// Accumulates cfg_groups+1 beats per lane and emits one vector per group; result one cycle after last beat.
// Backpressure: in_ready drops only while a result is held and out_ready is low.
module channel_accumulator_p
  import channel_accumulator_p_pkg::*;
#(
  parameter int LANES = DEF_LANES,
  parameter int IN_W  = DEF_IN_W,
  parameter int ACC_W = DEF_ACC_W,
  parameter int CNT_W = DEF_CNT_W,
  parameter int SAT   = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [CNT_W-1:0]       cfg_groups,
  input  logic                   clear,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*IN_W-1:0]  in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*ACC_W-1:0] out_data,
  output logic [LANES-1:0]       ovf,
  output logic                   busy
);

  logic [LANES*ACC_W-1:0] acc;
  logic [LANES*ACC_W-1:0] sum_vec;
  logic [LANES-1:0]       lane_ovf;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       grp_len;
  logic                   idle;
  logic                   accept;
  logic                   take;
  logic                   last;

  assign idle     = (cnt == '0);
  assign busy     = ~idle;
  assign in_ready = ~out_valid | out_ready;
  assign accept   = in_valid & in_ready & ~clear;
  assign take     = out_valid & out_ready;
  // The first beat of a group decides its length from the live config.
  assign last     = idle ? (cfg_groups == '0) : (cnt == grp_len);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    chacc_lane #(
      .IN_W  (IN_W),
      .ACC_W (ACC_W),
      .SAT   (SAT)
    ) u_lane (
      .in_lane (in_data[lane_lsb(i, IN_W) +: IN_W]),
      .acc     (acc[lane_lsb(i, ACC_W) +: ACC_W]),
      .first   (idle),
      .sum     (sum_vec[lane_lsb(i, ACC_W) +: ACC_W]),
      .ovf     (lane_ovf[i])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc       <= '0;
      cnt       <= '0;
      grp_len   <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      ovf       <= '0;
    end else begin
      if (take) begin
        out_valid <= 1'b0;
      end
      if (clear) begin
        acc <= '0;
        cnt <= '0;
        ovf <= '0;
      end else if (accept) begin
        ovf <= ovf | lane_ovf;
        if (idle) begin
          grp_len <= cfg_groups;
        end
        if (last) begin
          out_data  <= sum_vec;
          out_valid <= 1'b1;
          acc       <= '0;
          cnt       <= '0;
        end else begin
          acc <= sum_vec;
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_channel_accumulator_p.sv
module tb_channel_accumulator_p;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [4:0]   cfg = '0;
  logic         clr = 1'b0;
  logic         iv = 1'b0;
  logic         ordy = 1'b0;
  logic [175:0] idat = '0;
  logic         ir;
  logic         ov;
  logic [255:0] odat;
  logic [15:0]  ovf_o;
  logic         bsy;

  // Narrow 4-lane, 12-bit copies (saturating and wrapping) sharing one stimulus.
  logic [4:0]   s_cfg = '0;
  logic         s_iv = 1'b0;
  logic         s_rdy = 1'b1;
  logic [43:0]  s_dat = '0;
  logic         sat_ir, sat_ov, sat_bsy, wrp_ir, wrp_ov, wrp_bsy;
  logic [47:0]  sat_out, wrp_out;
  logic [3:0]   sat_ovf, wrp_ovf;

  int n_checks = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  channel_accumulator_p u_dut (
    .clk(clk), .rst(rst), .cfg_groups(cfg), .clear(clr), .in_valid(iv), .in_ready(ir),
    .in_data(idat), .out_valid(ov), .out_ready(ordy), .out_data(odat), .ovf(ovf_o), .busy(bsy)
  );

  channel_accumulator_p #(.LANES(4), .IN_W(11), .ACC_W(12), .CNT_W(5), .SAT(1)) u_sat (
    .clk(clk), .rst(rst), .cfg_groups(s_cfg), .clear(1'b0), .in_valid(s_iv), .in_ready(sat_ir),
    .in_data(s_dat), .out_valid(sat_ov), .out_ready(s_rdy), .out_data(sat_out), .ovf(sat_ovf), .busy(sat_bsy)
  );

  channel_accumulator_p #(.LANES(4), .IN_W(11), .ACC_W(12), .CNT_W(5), .SAT(0)) u_wrp (
    .clk(clk), .rst(rst), .cfg_groups(s_cfg), .clear(1'b0), .in_valid(s_iv), .in_ready(wrp_ir),
    .in_data(s_dat), .out_valid(wrp_ov), .out_ready(s_rdy), .out_data(wrp_out), .ovf(wrp_ovf), .busy(wrp_bsy)
  );

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  // Running fold of a lane's beats with per-add saturation or wrap.
  function automatic longint fold_q(input longint vals[$], input int accw, input bit sat, output bit ovfl);
    longint lim, a, s;
    lim = longint'(1) << (accw - 1);
    a = 0;
    ovfl = 1'b0;
    foreach (vals[k]) begin
      s = a + vals[k];
      if (s > lim - 1 || s < -lim) begin
        ovfl = 1'b1;
        if (sat) s = (s > 0) ? lim - 1 : -lim;
        else begin
          s = s & (2 * lim - 1);
          if (s >= lim) s = s - 2 * lim;
        end
      end
      a = s;
    end
    return a;
  endfunction

  // Behavioural model of the default-parameter instance: beats of the open group kept as a list.
  logic [175:0] beats[$];
  int           m_len = 0;
  logic         m_ov = 1'b0;
  logic [255:0] m_out = '0;
  logic [15:0]  m_ovf = '0;
  bit           m_take, m_acc;

  function automatic longint fold_group(input int l, output bit ovfl);
    longint q[$];
    foreach (beats[k]) q.push_back(longint'($signed(beats[k][l*11 +: 11])));
    return fold_q(q, 16, 1'b1, ovfl);
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      beats.delete();
      m_len = 0;
      m_ov = 1'b0;
      m_out = '0;
      m_ovf = '0;
    end else begin
      m_take = m_ov && ordy;
      m_acc = iv && (!m_ov || ordy) && !clr;
      if (m_take) m_ov = 1'b0;
      if (clr) begin
        beats.delete();
        m_ovf = '0;
      end else if (m_acc) begin
        if (beats.size() == 0) m_len = int'(cfg);
        beats.push_back(idat);
        for (int l = 0; l < 16; l++) begin
          bit    o;
          longint v;
          v = fold_group(l, o);
          if (o) m_ovf[l] = 1'b1;
          if (beats.size() == m_len + 1) m_out[l*16 +: 16] = 16'(v);
        end
        if (beats.size() == m_len + 1) begin
          m_ov = 1'b1;
          beats.delete();
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("cmp_in_ready", 256'(ir), 256'(!m_ov || ordy));
    chk("cmp_out_valid", 256'(ov), 256'(m_ov));
    chk("cmp_busy", 256'(bsy), 256'(beats.size() != 0));
    chk("cmp_ovf", 256'(ovf_o), 256'(m_ovf));
    chk("cmp_out_data", odat, m_out);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int l, input int v);
    idat[l*11 +: 11] = 11'(v);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  initial begin
    longint q[$];
    bit     o;
    longint r;
    int     l3_seq[4];
    int     g3_l3[3];
    int     g3_l5[3];

    // Pin the reference fold with hand-computed values.
    q = '{1023, 1023, 1023, 1023};
    r = fold_q(q, 12, 1'b0, o);
    chk("model_wrap_l0", 256'(r), 256'(longint'(-4)));
    chk("model_wrap_l0_ovf", 256'(o), 256'(1'b1));
    r = fold_q(q, 12, 1'b1, o);
    chk("model_sat_l0", 256'(r), 256'(longint'(2047)));
    q = '{1000, 1000, 1000, -1000};
    r = fold_q(q, 12, 1'b1, o);
    chk("model_sat_l3", 256'(r), 256'(longint'(1047)));
    r = fold_q(q, 12, 1'b0, o);
    chk("model_wrap_l3", 256'(r), 256'(longint'(2000)));

    tick();
    tick();
    chk("rst_out_valid", 256'(ov), 256'(1'b0));
    chk("rst_busy", 256'(bsy), 256'(1'b0));
    chk("rst_ovf", 256'(ovf_o), 256'(16'h0));
    chk("rst_out_data", odat, 256'(0));
    rst = 1'b1;
    tick();

    // Narrow instances: 4 beats per group, saturate vs wrap at 12 bits.
    l3_seq = '{1000, 1000, 1000, -1000};
    s_cfg = 5'd3;
    for (int k = 0; k < 4; k++) begin
      s_dat[0 +: 11]  = 11'(1023);
      s_dat[11 +: 11] = 11'(-1000);
      s_dat[22 +: 11] = 11'(5);
      s_dat[33 +: 11] = 11'(l3_seq[k]);
      s_iv = 1'b1;
      tick();
    end
    s_iv = 1'b0;
    chk("sat_valid", 256'(sat_ov), 256'(1'b1));
    chk("sat_data", 256'(sat_out), 256'({12'h417, 12'h014, 12'h800, 12'h7FF}));
    chk("sat_ovf", 256'(sat_ovf), 256'(4'b1011));
    chk("wrap_valid", 256'(wrp_ov), 256'(1'b1));
    chk("wrap_data", 256'(wrp_out), 256'({12'h7D0, 12'h014, 12'h060, 12'hFFC}));
    chk("wrap_ovf", 256'(wrp_ovf), 256'(4'b1011));
    tick();

    // Pass-through.
    ordy = 1'b1;
    cfg = 5'd0;
    idat = '0;
    set_lane(0, -5);
    iv = 1'b1;
    tick();
    iv = 1'b0;
    chk("pt_valid", 256'(ov), 256'(1'b1));
    chk("pt_lane0", 256'(odat[15:0]), 256'(16'hFFFB));
    chk("pt_busy", 256'(bsy), 256'(1'b0));

    // Group of three.
    g3_l3 = '{100, -30, 7};
    g3_l5 = '{1, 2, 3};
    cfg = 5'd2;
    for (int k = 0; k < 3; k++) begin
      idat = '0;
      set_lane(3, g3_l3[k]);
      set_lane(5, g3_l5[k]);
      set_lane(15, -1024);
      iv = 1'b1;
      tick();
      if (k == 0) chk("g3_busy", 256'(bsy), 256'(1'b1));
      if (k == 1) chk("g3_not_yet", 256'(ov), 256'(1'b0));
    end
    iv = 1'b0;
    chk("g3_valid", 256'(ov), 256'(1'b1));
    chk("g3_lane3", 256'(odat[63:48]), 256'(16'd77));
    chk("g3_lane5", 256'(odat[95:80]), 256'(16'd6));
    chk("g3_lane15", 256'(odat[255:240]), 256'(16'hF400));

    // Back-pressure: held result blocks a new last beat until taken.
    ordy = 1'b0;
    cfg = 5'd0;
    idat = '0;
    set_lane(0, 9);
    iv = 1'b1;
    #1;
    chk("bp_in_ready", 256'(ir), 256'(1'b0));
    tick();
    chk("bp_held_lane3", 256'(odat[63:48]), 256'(16'd77));
    chk("bp_held_valid", 256'(ov), 256'(1'b1));
    ordy = 1'b1;
    tick();
    iv = 1'b0;
    chk("bp_reload_valid", 256'(ov), 256'(1'b1));
    chk("bp_reload_lane0", 256'(odat[15:0]), 256'(16'd9));
    tick();

    // Clear mid-group; the beat presented with clear is dropped.
    cfg = 5'd3;
    idat = '0;
    set_lane(0, 50);
    iv = 1'b1;
    tick();
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    iv = 1'b0;
    chk("clr_busy", 256'(bsy), 256'(1'b0));
    set_lane(0, 10);
    iv = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    iv = 1'b0;
    chk("clr_valid", 256'(ov), 256'(1'b1));
    chk("clr_lane0", 256'(odat[15:0]), 256'(16'd40));
    chk("clr_ovf", 256'(ovf_o), 256'(16'h0));

    // Async reset between edges with a partial group open.
    cfg = 5'd2;
    set_lane(0, 3);
    iv = 1'b1;
    tick();
    tick();
    iv = 1'b0;
    chk("ar_busy_before", 256'(bsy), 256'(1'b1));
    rst = 1'b0;
    #1;
    chk("ar_out_valid", 256'(ov), 256'(1'b0));
    chk("ar_busy", 256'(bsy), 256'(1'b0));
    chk("ar_ovf", 256'(ovf_o), 256'(16'h0));
    chk("ar_out_data", odat, 256'(0));
    rst = 1'b1;
    tick();
    cfg = 5'd1;
    idat = '0;
    set_lane(0, 3);
    iv = 1'b1;
    tick();
    set_lane(0, 4);
    tick();
    iv = 1'b0;
    chk("ar_next_valid", 256'(ov), 256'(1'b1));
    chk("ar_next_lane0", 256'(odat[15:0]), 256'(16'd7));

    // Randomised traffic checked by the model every cycle.
    for (int c = 0; c < 3000; c++) begin
      cfg = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 4));
      iv = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 9) < 7);
      clr = ($urandom_range(0, 49) == 0);
      for (int l = 0; l < 16; l++) begin
        if ($urandom_range(0, 4) == 0) set_lane(l, ($urandom_range(0, 1) != 0) ? 1023 : -1024);
        else idat[l*11 +: 11] = 11'($urandom);
      end
      tick();
    end
    iv = 1'b0;
    clr = 1'b0;
    ordy = 1'b1;
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
